// File: rtl/float_multiplier.sv
// Sequential IEEE-754 single-precision multiplier with stb/ack handshakes.
// Round-to-nearest-even, full denormal support, one operation in flight.
module float_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam int unsigned DW = 32;
  localparam int unsigned MW = 24;
  localparam int unsigned EW = 10;
  localparam int unsigned PW = 48;

  localparam logic signed [EW-1:0] E_MIN  = -10'sd126;
  localparam logic signed [EW-1:0] E_MAX  = 10'sd127;
  localparam logic        [DW-1:0] QNAN_Z = 32'h7FC0_0000;

  typedef enum logic [3:0] {
    S_GET_A, S_GET_B, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B, S_MUL_0,
    S_MUL_1, S_NORM_1, S_NORM_2, S_ROUND, S_PACK, S_PUT_Z
  } state_t;

  state_t r_state, w_next;

  logic [DW-1:0]        r_a, r_b, r_z;
  logic [MW-1:0]        r_a_m, r_b_m, r_z_m;
  logic signed [EW-1:0] r_a_e, r_b_e, r_z_e;
  logic                 r_a_s, r_b_s, r_z_s;
  logic                 r_guard, r_round, r_sticky;
  logic [PW-1:0]        r_product;
  logic                 r_a_ack, r_b_ack, r_z_stb;

  logic          w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
  logic          w_is_special;
  logic [DW-1:0] w_special_z, w_pack_z;
  logic [7:0]    w_pack_exp;

  assign input_a_ack  = r_a_ack;
  assign input_b_ack  = r_b_ack;
  assign output_z     = r_z;
  assign output_z_stb = r_z_stb;

  // Operand classification straight from the latched raw words
  always_comb begin
    w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
    w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
    w_a_zero = (r_a[30:23] == 8'h00) && (r_a[22:0] == 23'd0);
    w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
    w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
    w_b_zero = (r_b[30:23] == 8'h00) && (r_b[22:0] == 23'd0);
    w_is_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
    w_special_z  = {r_a[31] ^ r_b[31], 31'd0};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_special_z = QNAN_Z;
    else if (w_a_inf || w_b_inf)
      w_special_z = {r_a[31] ^ r_b[31], 8'hFF, 23'd0};
  end

  // Result packing, including denormal encoding and overflow to infinity
  always_comb begin
    w_pack_exp = 8'(r_z_e + 10'sd127);
    if ((r_z_e == E_MIN) && !r_z_m[23])
      w_pack_exp = 8'd0;
    w_pack_z = {r_z_s, w_pack_exp, r_z_m[22:0]};
    if (r_z_e > E_MAX)
      w_pack_z = {r_z_s, 8'hFF, 23'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_GET_A;
    else     r_state <= w_next;
  end

  // Normalise states leave in the cycle whose shift completes normalisation
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_GET_A:   if (r_a_ack && input_a_stb) w_next = S_GET_B;
      S_GET_B:   if (r_b_ack && input_b_stb) w_next = S_UNPACK;
      S_UNPACK:  w_next = S_SPECIAL;
      S_SPECIAL: w_next = w_is_special ? S_PUT_Z : S_NORM_A;
      S_NORM_A:  if (r_a_m[23] || r_a_m[22]) w_next = S_NORM_B;
      S_NORM_B:  if (r_b_m[23] || r_b_m[22]) w_next = S_MUL_0;
      S_MUL_0:   w_next = S_MUL_1;
      S_MUL_1:   w_next = S_NORM_1;
      S_NORM_1:  if (r_z_m[23] || r_z_m[22]) w_next = S_NORM_2;
      S_NORM_2:  if (r_z_e >= (E_MIN - 10'sd1)) w_next = S_ROUND;
      S_ROUND:   w_next = S_PACK;
      S_PACK:    w_next = S_PUT_Z;
      S_PUT_Z:   if (r_z_stb && output_z_ack) w_next = S_GET_A;
      default:   w_next = S_GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_z_stb <= 1'b0;
      r_z     <= '0;
    end else begin
      case (r_state)
        S_GET_A: begin
          r_a_ack <= 1'b1;
          if (r_a_ack && input_a_stb) begin
            r_a     <= input_a;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b1;
          end
        end
        S_GET_B: begin
          r_b_ack <= 1'b1;
          if (r_b_ack && input_b_stb) begin
            r_b     <= input_b;
            r_b_ack <= 1'b0;
          end
        end
        S_UNPACK: begin
          r_a_m <= {1'b0, r_a[22:0]};
          r_b_m <= {1'b0, r_b[22:0]};
          r_a_e <= 10'({2'b00, r_a[30:23]}) - 10'sd127;
          r_b_e <= 10'({2'b00, r_b[30:23]}) - 10'sd127;
          r_a_s <= r_a[31];
          r_b_s <= r_b[31];
        end
        S_SPECIAL: begin
          if (w_is_special) begin
            r_z     <= w_special_z;
            r_z_stb <= 1'b1;
          end else begin
            if (r_a[30:23] == 8'h00) r_a_e <= E_MIN;
            else                     r_a_m[23] <= 1'b1;
            if (r_b[30:23] == 8'h00) r_b_e <= E_MIN;
            else                     r_b_m[23] <= 1'b1;
          end
        end
        S_NORM_A: begin
          if (!r_a_m[23]) begin
            r_a_m <= {r_a_m[22:0], 1'b0};
            r_a_e <= r_a_e - 10'sd1;
          end
        end
        S_NORM_B: begin
          if (!r_b_m[23]) begin
            r_b_m <= {r_b_m[22:0], 1'b0};
            r_b_e <= r_b_e - 10'sd1;
          end
        end
        S_MUL_0: begin
          r_z_s     <= r_a_s ^ r_b_s;
          r_z_e     <= r_a_e + r_b_e + 10'sd1;
          r_product <= PW'(r_a_m) * PW'(r_b_m);
        end
        S_MUL_1: begin
          r_z_m    <= r_product[47:24];
          r_guard  <= r_product[23];
          r_round  <= r_product[22];
          r_sticky <= |r_product[21:0];
        end
        S_NORM_1: begin
          if (!r_z_m[23]) begin
            r_z_m   <= {r_z_m[22:0], r_guard};
            r_guard <= r_round;
            r_round <= 1'b0;
            r_z_e   <= r_z_e - 10'sd1;
          end
        end
        S_NORM_2: begin
          // Denormalise tiny results, folding shifted-out bits into sticky
          if (r_z_e < E_MIN) begin
            r_z_e    <= r_z_e + 10'sd1;
            r_z_m    <= {1'b0, r_z_m[23:1]};
            r_guard  <= r_z_m[0];
            r_round  <= r_guard;
            r_sticky <= r_sticky | r_round;
          end
        end
        S_ROUND: begin
          if (r_guard && (r_round || r_sticky || r_z_m[0])) begin
            r_z_m <= r_z_m + 24'd1;
            if (r_z_m == 24'hFF_FFFF) r_z_e <= r_z_e + 10'sd1;
          end
        end
        S_PACK: begin
          r_z     <= w_pack_z;
          r_z_stb <= 1'b1;
        end
        S_PUT_Z: begin
          if (r_z_stb && output_z_ack) begin
            r_z_stb <= 1'b0;
            r_a_ack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_multiplier.sv
// Self-checking bench for float_multiplier: directed operands, a queue of
// expected products, latency, backpressure and mid-operation reset checks.
module tb_float_multiplier;

  localparam int BUDGET = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b, output_z;
  logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
  logic        output_z_stb, output_z_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];

  float_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, want);
    end
  endtask

  // Drives A and B together; returns the cycle stamp of the B-accept edge
  task automatic send_ab(input string tag, input logic [31:0] a, input logic [31:0] b,
                         output int t_b, output bit ok);
    int n;
    ok = 1'b0;
    t_b = cyc;
    input_a = a; input_b = b;
    input_a_stb = 1'b1; input_b_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < BUDGET) begin @(negedge clk); n++; end
    if (!input_a_ack) begin
      check_eq({tag, "_a_ack_timeout"}, 32'(input_a_ack), 32'd1);
      input_a_stb = 1'b0; input_b_stb = 1'b0;
      return;
    end
    check_eq({tag, "_b_ack_before_a"}, 32'(input_b_ack), 32'd0);
    @(posedge clk); @(negedge clk);
    input_a_stb = 1'b0;
    check_eq({tag, "_a_ack_drop"}, 32'(input_a_ack), 32'd0);
    n = 0;
    while (!input_b_ack && n < BUDGET) begin @(negedge clk); n++; end
    if (!input_b_ack) begin
      check_eq({tag, "_b_ack_timeout"}, 32'(input_b_ack), 32'd1);
      input_b_stb = 1'b0;
      return;
    end
    @(posedge clk); @(negedge clk);
    input_b_stb = 1'b0;
    t_b = cyc;
    ok = 1'b1;
  endtask

  // Waits for a product, compares it with the scoreboard head, then takes it
  task automatic recv_z(input string tag, input int t_b, input int lat, input int hold);
    int n;
    logic [31:0] want;
    want = exp_q.pop_front();
    n = 0;
    while (!output_z_stb && n < BUDGET) begin @(negedge clk); n++; end
    if (!output_z_stb) begin
      check_eq({tag, "_z_timeout"}, 32'(output_z_stb), 32'd1);
      return;
    end
    if (lat >= 0) check_eq({tag, "_latency"}, 32'(cyc - t_b), 32'(lat));
    check_eq(tag, output_z, want);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq({tag, "_bp_z"}, output_z, want);
      check_eq({tag, "_bp_stb_acks"}, {29'd0, output_z_stb, input_a_ack, input_b_ack}, 32'd4);
    end
    output_z_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    output_z_ack = 1'b0;
    check_eq({tag, "_stb_drop_a_ack"}, {30'd0, output_z_stb, input_a_ack}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input int lat, input int hold);
    int t_b;
    bit ok;
    exp_q.push_back(want);
    send_ab(tag, a, b, t_b, ok);
    if (ok) recv_z(tag, t_b, lat, hold);
    else void'(exp_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_b;
    bit ok;
    bit seen;
    rst = 1'b1;
    input_a = '0; input_b = '0;
    input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {28'd0, input_a_ack, input_b_ack, output_z_stb, |output_z}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_a_ack_rise", {30'd0, input_a_ack, input_b_ack}, 32'd2);

    run_op("mul_2x3",       32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 10, 5);
    run_op("sign",          32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000, 10, 0);
    run_op("inf_x_zero",    32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2, 0);
    run_op("negzero_x_one", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 2, 0);
    run_op("nan_in",        32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 2, 0);
    run_op("inf_x_neg2",    32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 2, 0);
    run_op("overflow",      32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 10, 0);
    run_op("underflow",     32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 10, 0);
    run_op("one_x_one",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 10, 0);
    run_op("sticky_down",   32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 10, 0);
    run_op("near_four",     32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 10, 0);
    run_op("tie_even_up",   32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 10, 0);
    run_op("denorm_in",     32'h0000_0001, 32'h4B00_0000, 32'h0080_0000, -1, 0);

    // Abort an operation while it sits in multiply_0
    send_ab("abort", 32'h4000_0000, 32'h4040_0000, t_b, ok);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("abort_outputs", {28'd0, input_a_ack, input_b_ack, output_z_stb, |output_z}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_a_ack_rise", 32'(input_a_ack), 32'd1);
    seen = 1'b0;
    repeat (15) begin @(negedge clk); seen |= output_z_stb; end
    check_eq("abort_no_strobe", 32'(seen), 32'd0);
    run_op("after_abort", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 10, 0);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_multiplier.md
# float_multiplier

Sequential IEEE-754 single-precision multiplier using the same stb/ack handshake as the float adder. It sits directly upstream of the adder and produces the products that the adder sums for dot products and squared distances in the collision pipeline. Its `output_z`/`output_z_stb`/`output_z_ack` connect directly to the adder's `input_a` or `input_b` triple. Round-to-nearest-even, full denormal support, one operation in flight.

## Interface
- Parameters: none.
- `clk` in 1: sole clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `input_a` in 32: operand A, IEEE-754 single.
- `input_a_stb` in 1: A valid.
- `input_a_ack` out 1: A accepted; the transfer happens on the edge where stb and ack are both high.
- `input_b` in 32: operand B.
- `input_b_stb` in 1: B valid.
- `input_b_ack` out 1: B accepted.
- `output_z` out 32: product.
- `output_z_stb` out 1: product valid.
- `output_z_ack` in 1: consumer accepted product.

## Operation
- The FSM steps through get_a, get_b, unpack, special_cases, normalise_a, normalise_b, multiply_0, multiply_1, normalise_1, normalise_2, round, pack and put_z, then returns to get_a.
- **get_a:** `input_a_ack`=1.
  - On stb&&ack, latch A, drop ack and go to get_b.
- **get_b:** same as get_a, for B.
- **unpack:**
  - mantissa = 24 bits, {0, frac}.
  - exponent = 10-bit signed, field−127.
  - sign latched.
- **special_cases:** evaluated in priority order.
  - If either operand is NaN, or inf×0, z=0x7FC00000.
  - Else if either operand is inf, z = {sa^sb, 0xFF, 0}.
  - Else if either operand is zero (exp field 0 and frac 0), z = {sa^sb, 31'b0}.
  - Each special case goes to put_z.
  - Otherwise:
    - For an exp field of 0 (denormal), set exponent = −126.
    - For any other exp field, set mantissa bit 23 = 1.
    - Go to normalise_a.
- **normalise_a / normalise_b:**
  - While mantissa[23]==0, shift left 1 and decrement exponent, one step per cycle.
  - Exit after 1 cycle if already normalised.
- **multiply_0:**
  - z_s = sa^sb.
  - z_e = ea+eb+1.
  - product = ma×mb (48 bits).
- **multiply_1:**
  - z_m = product[47:24].
  - guard = product[23].
  - round_bit = product[22].
  - sticky = |product[21:0].
- **normalise_1:**
  - While z_m[23]==0: shift {z_m,guard} left, guard←round_bit, round_bit←0, z_e−1.
  - One step per cycle.
- **normalise_2:**
  - While z_e < −126: z_e+1, shift right, guard←z_m[0], round_bit←guard, sticky|=round_bit.
  - One step per cycle.
- **round:**
  - If guard && (round_bit|sticky|z_m[0]), increment z_m.
  - If z_m was 0xFFFFFF before the increment, z_e+1.
- **pack:**
  - Exp field = z_e+127, frac = z_m[22:0].
  - If z_e==−126 and z_m[23]==0, exp field = 0 (denormal/zero result).
  - If z_e>127, z = {z_s, 0xFF, 0} (overflow to inf).
- **put_z:**
  - `output_z_stb`=1, output_z held stable.
  - On stb&&ack, drop stb and go to get_a.

## Timing
- **Reset values:** `input_a_ack`=0, `input_b_ack`=0, `output_z_stb`=0, `output_z`=0, state=get_a. `input_a_ack` rises on the first edge after reset deasserts.
- **Reset mid-operation:** aborts any in-flight operation the next edge; the partial result is discarded and never strobed.
- **Acks:** each ack is high for exactly one accepting cycle per transfer. B is not accepted before A. Simultaneous stb on both inputs still serialises A then B.
- **Latency, normal operands with normal result and no extra normalisation steps:**
  - `output_z_stb` rises 10 edges after the B-accept edge.
  - Sequence: unpack, special, norm_a, norm_b, mul0, mul1, norm1, norm2, round, pack.
  - Each extra normalisation shift adds 1 cycle.
- **Special-case latency:** `output_z_stb` rises 2 edges after B accept.
- **Backpressure:** `output_z_stb` and `output_z` hold indefinitely while `output_z_ack`=0. No new operand is accepted until Z is taken.
- **Throughput:** one result per (latency + 3) cycles minimum.

## Test plan
- **Basic product:** A=0x40000000 (2.0), B=0x40400000 (3.0) → z=0x40C00000, stb exactly 10 cycles after B accept.
- **Sign:** A=0x3FC00000 (1.5), B=0xC0000000 (−2.0) → z=0xC0400000.
- **Special cases:**
  - A=0x7F800000 (inf), B=0x00000000 → z=0x7FC00000, 2-cycle latency.
  - A=0x80000000, B=0x3F800000 → z=0x80000000.
- **Overflow / underflow:**
  - A=B=0x7F000000 → z=0x7F800000.
  - A=0x00800000, B=0x3F000000 → denormal z=0x00400000.
- **Backpressure:** hold `output_z_ack`=0 for 5 cycles after stb → z and stb stable throughout, both acks stay 0; ack on cycle 6 → stb drops next edge and `input_a_ack` rises.
- **Reset mid-operation:** assert rst during multiply_0 → next edge all outputs 0 and state get_a; the following 2.0×3.0 still yields 0x40C00000.
